// File: rtl/dmem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// dmem_port_arbiter_if
// Request/acknowledge bus used by the auxiliary data-memory master (loader,
// debug unit or DMA) to reach the shared data memory through the arbiter.
//
// Signals:
//   b_req    master -> arbiter  request, held high until b_ack
//   b_we     master -> arbiter  1 = write, 0 = read; stable while b_req high
//   b_addr   master -> arbiter  access address; stable while b_req high
//   b_wdata  master -> arbiter  write data; stable while b_req high
//   b_ack    arbiter -> master  one-cycle pulse, access completed
//   b_rdata  arbiter -> master  read data, valid with b_ack, held until next ack
//
// Modports: master (the auxiliary agent), slave (the arbiter).
// ---------------------------------------------------------------------------
interface dmem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              b_req;
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic              b_ack;
  logic [DATA_W-1:0] b_rdata;

  modport master (
    output b_req, b_we, b_addr, b_wdata,
    input  b_ack, b_rdata
  );

  modport slave (
    input  b_req, b_we, b_addr, b_wdata,
    output b_ack, b_rdata
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_port_arbiter
// Shares the single-port data memory between the pipeline MEM stage (port C,
// normally highest priority) and an auxiliary bus master (port B). B is only
// allowed to take the memory away from an active C access after it has been
// waiting MAX_WAIT cycles; in that cycle the pipeline is stalled.
//
// Parameters:
//   ADDR_W    address width (both ports and memory side)
//   DATA_W    data width
//   MAX_WAIT  cycles B may wait behind a busy C before it is forced through
//             (0 = B always wins)
//   STAT_W    width of the statistics counters
//
// Ports:
//   clk, reset             clock, asynchronous active-low reset
//   bPort (slave modport)  B req/ack bus
//   c_MemRead, c_MemWr     MEM-stage read/write enables
//   c_addr, c_wdata        MEM-stage address / store data
//   c_rdata                MEM-stage read data (pass-through of m_rdata)
//   c_stall                1 = C access not performed this cycle
//   m_MemRead, m_MemWr     data-memory enables
//   m_addr, m_wdata        data-memory address / write data
//   m_rdata                data-memory read data (combinational read)
//   stat_b_cnt             number of B grants (statistics build only)
//   stat_stall             number of C stall cycles (statistics build only)
//
// Configuration macro: DMEM_ARB_STATS_EN enables the saturating statistics
// counters; without it both statistics outputs are tied to zero.
// ---------------------------------------------------------------------------
module dmem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4,
  parameter int STAT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  dmem_port_arbiter_if.slave bPort,
  input  logic              c_MemRead,
  input  logic              c_MemWr,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic [DATA_W-1:0] c_rdata,
  output logic              c_stall,
  output logic              m_MemRead,
  output logic              m_MemWr,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  output logic [STAT_W-1:0] stat_b_cnt,
  output logic [STAT_W-1:0] stat_stall
);

  localparam int WCNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WCNT_W-1:0] MAX_CNT = WCNT_W'(MAX_WAIT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK
  } state_t;

  state_t            state_q;
  logic [WCNT_W-1:0] wait_cnt_q;
  logic [WCNT_W-1:0] wait_cnt_inc;
  logic              b_ack_q;
  logic [DATA_W-1:0] b_rdata_q;

  logic c_act;
  logic grant_b;

  assign c_act = c_MemRead | c_MemWr;

  // B is granted whenever C leaves the memory free, or when B's wait has hit
  // the bound. The ACK cycle is a dead cycle so a held b_req cannot be
  // granted twice. Qualifying with reset keeps the memory quiet during reset.
  assign grant_b = reset && (state_q != S_ACK) && bPort.b_req &&
                   (!c_act || (wait_cnt_q == MAX_CNT));

  assign wait_cnt_inc = (wait_cnt_q == MAX_CNT) ? wait_cnt_q : wait_cnt_q + 1'b1;

  // Memory-side mux. When B wins, any C access (including a store) is simply
  // not issued and the stall makes the pipeline retry it next cycle.
  assign m_MemRead = reset && (grant_b ? !bPort.b_we : c_MemRead);
  assign m_MemWr   = reset && (grant_b ?  bPort.b_we : c_MemWr);
  assign m_addr    = grant_b ? bPort.b_addr  : c_addr;
  assign m_wdata   = grant_b ? bPort.b_wdata : c_wdata;
  assign c_stall   = grant_b && c_act;
  assign c_rdata   = m_rdata;

  assign bPort.b_ack   = b_ack_q;
  assign bPort.b_rdata = b_rdata_q;

  // Arbitration FSM. The wait counter already counts the first refused cycle
  // in IDLE, so a B request that arrives while C is busy is forced through
  // after exactly MAX_WAIT refused cycles (ack MAX_WAIT+1 cycles after req).
  // Dropping b_req while waiting abandons the request without an ack.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
      b_ack_q    <= 1'b0;
      b_rdata_q  <= '0;
    end else begin
      b_ack_q <= grant_b;
      if (grant_b && !bPort.b_we) begin
        b_rdata_q <= m_rdata;
      end
      case (state_q)
        S_IDLE: begin
          if (grant_b) begin
            state_q    <= S_ACK;
            wait_cnt_q <= '0;
          end else if (bPort.b_req) begin
            state_q    <= S_WAIT;
            wait_cnt_q <= wait_cnt_inc;
          end
        end
        S_WAIT: begin
          if (grant_b) begin
            state_q    <= S_ACK;
            wait_cnt_q <= '0;
          end else if (!bPort.b_req) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= '0;
          end else begin
            wait_cnt_q <= wait_cnt_inc;
          end
        end
        S_ACK: begin
          state_q    <= S_IDLE;
          wait_cnt_q <= '0;
        end
        default: begin
          state_q    <= S_IDLE;
          wait_cnt_q <= '0;
        end
      endcase
    end
  end

`ifdef DMEM_ARB_STATS_EN
  logic [STAT_W-1:0] stat_b_cnt_q;
  logic [STAT_W-1:0] stat_stall_q;

  // Saturating event counters; they only return to zero through reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_b_cnt_q <= '0;
      stat_stall_q <= '0;
    end else begin
      if (grant_b && (stat_b_cnt_q != '1)) begin
        stat_b_cnt_q <= stat_b_cnt_q + 1'b1;
      end
      if (c_stall && (stat_stall_q != '1)) begin
        stat_stall_q <= stat_stall_q + 1'b1;
      end
    end
  end

  assign stat_b_cnt = stat_b_cnt_q;
  assign stat_stall = stat_stall_q;
`else
  assign stat_b_cnt = '0;
  assign stat_stall = '0;
`endif

endmodule
